// File: rtl/kbd_mouse_pkg.sv
// Shared codes for the kbd/mouse event block: event types, modifier keycodes
// and the helper that tracks Ctrl/LAmiga/RAmiga from a keycode byte.
package kbd_mouse_pkg;

    typedef enum logic [1:0] {
        KMS_MOUSE_X = 2'd0,
        KMS_MOUSE_Y = 2'd1,
        KMS_KEYCODE = 2'd2,
        KMS_OSD     = 2'd3
    } kms_type_e;

    localparam logic [6:0] KEY_CTRL    = 7'h63;
    localparam logic [6:0] KEY_LAMIGA  = 7'h66;
    localparam logic [6:0] KEY_RAMIGA  = 7'h67;
    localparam int         KEY_REL_BIT = 7;

    typedef struct packed {
        logic ctrl;
        logic lamiga;
        logic ramiga;
    } mod_flags_t;

    // Bit 7 of the keycode marks a release; non-modifier codes leave flags alone.
    function automatic mod_flags_t mod_update(input mod_flags_t cur, input logic [7:0] code);
        mod_flags_t w_nxt;
        logic       w_press;
        w_nxt   = cur;
        w_press = ~code[KEY_REL_BIT];
        case (code[6:0])
            KEY_CTRL:   w_nxt.ctrl   = w_press;
            KEY_LAMIGA: w_nxt.lamiga = w_press;
            KEY_RAMIGA: w_nxt.ramiga = w_press;
            default:    ;
        endcase
        return w_nxt;
    endfunction

endpackage

// File: rtl/kms_fifo.sv
// Synchronous show-ahead FIFO: head entry and valid visible with no read latency.
// A push into a full FIFO is dropped (o_drop) unless a pop frees a slot that cycle.
module kms_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             i_push_vld,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop_rdy,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_head_vld,
    output logic             o_drop
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = i_pop_rdy && !w_empty;
    assign w_push  = i_push_vld && (!w_full || w_pop);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

    assign o_head_vld = !w_empty;
    assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_drop     = i_push_vld && w_full && !w_pop;

endmodule

// File: rtl/kbd_mouse_events.sv
// Decodes level-toggle kbd/mouse byte events into mouse counters, a keycode FIFO,
// OSD key strobe and Ctrl+Amiga+Amiga reset; results land one clock after the event.
module kbd_mouse_events
    import kbd_mouse_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       kms_level,
    input  logic [1:0] kms_type,
    input  logic [7:0] kms_data,
    input  logic [2:0] mouse_buttons_in,
    output logic [7:0] mouse_x,
    output logic [7:0] mouse_y,
    output logic [2:0] mouse_btn,
    output logic [7:0] key_data,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_ovf,
    output logic [7:0] osd_key,
    output logic       osd_strobe,
    output logic       kbd_reset
);

    logic       r_lvl_q;
    logic [7:0] r_mouse_x;
    logic [7:0] r_mouse_y;
    logic [2:0] r_mouse_btn;
    logic       r_key_ovf;
    logic [7:0] r_osd_key;
    logic       r_osd_strobe;
    logic       r_kbd_reset;
    mod_flags_t r_mods;

    logic       w_event;
    kms_type_e  w_type;
    logic       w_mx_evt;
    logic       w_my_evt;
    logic       w_key_evt;
    logic       w_osd_evt;
    mod_flags_t w_mods_nxt;
    logic       w_drop;
    logic [7:0] w_head_dat;
    logic       w_head_vld;

    assign w_event   = kms_level ^ r_lvl_q;
    assign w_type    = kms_type_e'(kms_type);
    assign w_mx_evt  = w_event && (w_type == KMS_MOUSE_X);
    assign w_my_evt  = w_event && (w_type == KMS_MOUSE_Y);
    assign w_key_evt = w_event && (w_type == KMS_KEYCODE);
    assign w_osd_evt = w_event && (w_type == KMS_OSD);

    // kbd_reset is registered from the post-event flags so it tracks them with no extra lag.
    assign w_mods_nxt = w_key_evt ? mod_update(r_mods, kms_data) : r_mods;

    always_ff @(posedge clk_sys) begin
        r_lvl_q <= kms_level;
        if (reset) begin
            r_mouse_x    <= '0;
            r_mouse_y    <= '0;
            r_mouse_btn  <= '0;
            r_key_ovf    <= 1'b0;
            r_osd_key    <= '0;
            r_osd_strobe <= 1'b0;
            r_kbd_reset  <= 1'b0;
            r_mods       <= '0;
        end else begin
            r_mouse_btn  <= mouse_buttons_in;
            r_osd_strobe <= w_osd_evt;
            r_mods       <= w_mods_nxt;
            r_kbd_reset  <= w_mods_nxt.ctrl & w_mods_nxt.lamiga & w_mods_nxt.ramiga;
            r_key_ovf    <= r_key_ovf | w_drop;
            // Unsigned 8-bit add wraps identically to a signed delta.
            if (w_mx_evt)  r_mouse_x <= r_mouse_x + kms_data;
            if (w_my_evt)  r_mouse_y <= r_mouse_y + kms_data;
            if (w_osd_evt) r_osd_key <= kms_data;
        end
    end

    kms_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .i_push_vld (w_key_evt),
        .i_push_dat (kms_data),
        .i_pop_rdy  (key_ack),
        .o_head_dat (w_head_dat),
        .o_head_vld (w_head_vld),
        .o_drop     (w_drop)
    );

    assign mouse_x    = r_mouse_x;
    assign mouse_y    = r_mouse_y;
    assign mouse_btn  = r_mouse_btn;
    assign key_data   = w_head_dat;
    assign key_valid  = w_head_vld;
    assign key_ovf    = r_key_ovf;
    assign osd_key    = r_osd_key;
    assign osd_strobe = r_osd_strobe;
    assign kbd_reset  = r_kbd_reset;

endmodule

// File: tb/tb_kbd_mouse_events.sv
// Randomized + directed bench for kbd_mouse_events against a queue-based reference model.
module tb_kbd_mouse_events;

    localparam int DEPTH = 8;

    logic       clk_sys;
    logic       reset;
    logic       kms_level;
    logic [1:0] kms_type;
    logic [7:0] kms_data;
    logic [2:0] mouse_buttons_in;
    logic [7:0] mouse_x;
    logic [7:0] mouse_y;
    logic [2:0] mouse_btn;
    logic [7:0] key_data;
    logic       key_valid;
    logic       key_ack;
    logic       key_ovf;
    logic [7:0] osd_key;
    logic       osd_strobe;
    logic       kbd_reset;

    kbd_mouse_events #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys          (clk_sys),
        .reset            (reset),
        .kms_level        (kms_level),
        .kms_type         (kms_type),
        .kms_data         (kms_data),
        .mouse_buttons_in (mouse_buttons_in),
        .mouse_x          (mouse_x),
        .mouse_y          (mouse_y),
        .mouse_btn        (mouse_btn),
        .key_data         (key_data),
        .key_valid        (key_valid),
        .key_ack          (key_ack),
        .key_ovf          (key_ovf),
        .osd_key          (osd_key),
        .osd_strobe       (osd_strobe),
        .kbd_reset        (kbd_reset)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit lvl = 1'b0;

    // Reference model state, expressed directly in terms of the visible behaviour.
    int         m_mx, m_my;
    bit [2:0]   m_btn;
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit [7:0]   m_osd_key;
    bit         m_osd_strobe;
    bit         m_ctrl, m_lam, m_ram;
    bit         m_kbdrst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit rst, input bit ev, input bit [1:0] typ,
                                input bit [7:0] dat, input bit ack, input bit [2:0] btn);
        int sz;
        bit pop;
        if (rst) begin
            m_mx = 0; m_my = 0; m_btn = 0; m_q.delete(); m_ovf = 0;
            m_osd_key = 0; m_osd_strobe = 0;
            m_ctrl = 0; m_lam = 0; m_ram = 0; m_kbdrst = 0;
        end else begin
            sz  = m_q.size();
            pop = ack && (sz > 0);
            m_btn = btn;
            m_osd_strobe = 0;
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                case (typ)
                    2'd0: m_mx = (m_mx + int'($signed(dat)) + 256) % 256;
                    2'd1: m_my = (m_my + int'($signed(dat)) + 256) % 256;
                    2'd2: begin
                        if (sz < DEPTH || pop) m_q.push_back(dat);
                        else m_ovf = 1;
                        if (dat[6:0] == 7'h63) m_ctrl = !dat[7];
                        if (dat[6:0] == 7'h66) m_lam  = !dat[7];
                        if (dat[6:0] == 7'h67) m_ram  = !dat[7];
                    end
                    default: begin
                        m_osd_key = dat;
                        m_osd_strobe = 1;
                    end
                endcase
            end
            m_kbdrst = m_ctrl && m_lam && m_ram;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle at negedge.
    task automatic step(input bit rst, input bit ev, input bit [1:0] typ,
                        input bit [7:0] dat, input bit ack);
        if (ev) lvl = ~lvl;
        reset            = rst;
        kms_level        = lvl;
        kms_type         = ev ? typ : 2'($urandom);
        kms_data         = ev ? dat : 8'($urandom);
        key_ack          = ack;
        mouse_buttons_in = 3'($urandom);
        @(posedge clk_sys);
        model_update(rst, ev, typ, dat, ack, mouse_buttons_in);
        @(negedge clk_sys);
    endtask

    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("mouse_x", 32'(mouse_x), 32'(m_mx));
            chk("mouse_y", 32'(mouse_y), 32'(m_my));
            chk("mouse_btn", 32'(mouse_btn), 32'(m_btn));
            chk("key_valid", 32'(key_valid), 32'(m_q.size() > 0));
            chk("key_data", 32'(key_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
            chk("key_ovf", 32'(key_ovf), 32'(m_ovf));
            chk("osd_key", 32'(osd_key), 32'(m_osd_key));
            chk("osd_strobe", 32'(osd_strobe), 32'(m_osd_strobe));
            chk("kbd_reset", 32'(kbd_reset), 32'(m_kbdrst));
        end
    end

    bit       r_rst, r_ev, r_ack;
    bit [1:0] r_typ;
    bit [7:0] r_dat;

    initial begin
        reset = 1'b1; kms_level = 1'b0; kms_type = 2'd0; kms_data = 8'd0;
        key_ack = 1'b0; mouse_buttons_in = 3'd0;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_mouse_x", 32'(mouse_x), 32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_kbd_reset", 32'(kbd_reset), 32'h0);

        // Mouse X accumulation with signed wrap
        step(0, 1, 0, 8'h05, 0);
        chk("mx_first", 32'(mouse_x), 32'h05);
        step(0, 1, 0, 8'hFA, 0);
        chk("mx_neg", 32'(mouse_x), 32'hFF);
        chk("my_untouched", 32'(mouse_y), 32'h00);
        step(0, 1, 0, 8'h02, 0);
        chk("mx_wrap", 32'(mouse_x), 32'h01);
        step(0, 1, 1, 8'h80, 0);
        chk("my_update", 32'(mouse_y), 32'h80);

        // Nine keycodes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) step(0, 1, 2, 8'(8'h10 + i), 0);
        chk("ovf_valid", 32'(key_valid), 32'h1);
        chk("ovf_head", 32'(key_data), 32'h10);
        chk("ovf_flag", 32'(key_ovf), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 32'(key_data), 32'(8'h10 + i));
            step(0, 0, 0, 0, 1);
        end
        chk("drain_empty", 32'(key_valid), 32'h0);
        step(0, 0, 0, 0, 1);
        chk("ack_empty_ignored", 32'(key_valid), 32'h0);

        // Full FIFO with simultaneous push and pop
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 2, 8'(8'h20 + i), 0);
        step(0, 1, 2, 8'h28, 1);
        chk("full_pushpop_ovf", 32'(key_ovf), 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk("full_pushpop_data", 32'(key_data), 32'(8'h21 + i));
            step(0, 0, 0, 0, 1);
        end
        chk("full_pushpop_empty", 32'(key_valid), 32'h0);
        // Push into empty FIFO while acking: push only
        step(0, 1, 2, 8'h33, 1);
        chk("empty_pushack", 32'(key_data), 32'h33);

        // Ctrl + LAmiga + RAmiga
        step(1, 0, 0, 0, 0);
        step(0, 1, 2, 8'h63, 0);
        step(0, 1, 2, 8'h66, 0);
        chk("kbdrst_two", 32'(kbd_reset), 32'h0);
        step(0, 1, 2, 8'h67, 0);
        chk("kbdrst_set", 32'(kbd_reset), 32'h1);
        step(0, 1, 2, 8'hE6, 0);
        chk("kbdrst_clr", 32'(kbd_reset), 32'h0);

        // OSD key
        step(1, 0, 0, 0, 0);
        step(0, 1, 3, 8'h45, 0);
        chk("osd_key", 32'(osd_key), 32'h45);
        chk("osd_strobe_hi", 32'(osd_strobe), 32'h1);
        chk("osd_no_fifo", 32'(key_valid), 32'h0);
        step(0, 0, 0, 0, 0);
        chk("osd_strobe_lo", 32'(osd_strobe), 32'h0);

        // Reset with entries queued and level held high
        for (int i = 0; i < 3; i++) step(0, 1, 2, 8'(8'h50 + i), 0);
        if (!lvl) step(0, 1, 0, 8'h11, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_q_valid", 32'(key_valid), 32'h0);
        chk("rst_q_mx", 32'(mouse_x), 32'h0);
        chk("rst_q_osd", 32'(osd_key), 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("rst_release_noevt", 32'(key_valid), 32'h0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            r_rst = ($urandom_range(0, 299) == 0);
            r_ev  = $urandom_range(0, 1) == 1;
            r_typ = 2'($urandom);
            r_dat = 8'($urandom);
            if (r_typ == 2'd2 && $urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 2))
                    0:       r_dat[6:0] = 7'h63;
                    1:       r_dat[6:0] = 7'h66;
                    default: r_dat[6:0] = 7'h67;
                endcase
            end
            r_ack = (i < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step(r_rst, r_ev, r_typ, r_dat, r_ack);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/kbd_mouse_events.md
KBD_MOUSE_EVENTS -- requirements
Module: kbd_mouse_events

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of two, at least 2): keyboard FIFO entries.
REQ-002 SHALL have port clk_sys, input, 1: the only clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port kms_level, input, 1: toggles once per new kbd/mouse byte from the HPS I/O stage.
REQ-005 SHALL have port kms_type, input, 2: 0 mouse X, 1 mouse Y, 2 keycode, 3 OSD key.
REQ-006 SHALL have port kms_data, input, 8: byte qualified by the kms_level toggle.
REQ-007 SHALL have port mouse_buttons_in, input, 3: raw button state.
REQ-008 SHALL have ports mouse_x and mouse_y, output, 8 each: wrapping position counters.
REQ-009 SHALL have port mouse_btn, output, 3: registered button state.
REQ-010 SHALL have ports key_data (output, 8), key_valid (output, 1) and key_ack (input, 1): FIFO head handshake.
REQ-011 SHALL have port key_ovf, output, 1: sticky keycode-dropped flag.
REQ-012 SHALL have ports osd_key (output, 8) and osd_strobe (output, 1): OSD keycode plus 1-cycle pulse.
REQ-013 SHALL have port kbd_reset, output, 1: high while Ctrl, LAmiga and RAmiga are all held.

Function
REQ-014 SHALL register kms_level into lvl_q every cycle; event = kms_level XOR lvl_q; the event's action SHALL be visible on outputs one clock after the cycle the event is detected.
REQ-015 SHALL sample kms_type and kms_data only in the event cycle; both inputs are ignored in all other cycles.
REQ-016 Type 0 SHALL set mouse_x to mouse_x + kms_data, with kms_data as signed 8-bit and the sum modulo 256 (0xFF + 0x02 = 0x01; 0x00 + 0xFF = 0xFF).
REQ-017 Type 1 SHALL update mouse_y in the same way as REQ-016.
REQ-018 mouse_btn SHALL follow mouse_buttons_in with 1-cycle latency, independent of events.
REQ-019 Type 2 SHALL push kms_data into the FIFO and update modifier state.
REQ-020 Modifier state: bit7=0 is press, bit7=1 is release; codes[6:0] 0x63 Ctrl, 0x66 LAmiga, 0x67 RAmiga set/clear the matching flag; other codes leave flags unchanged.
REQ-021 kbd_reset SHALL be the registered AND of the three flags, updated with 1-cycle latency after the keycode event.
REQ-022 Type 3 SHALL load osd_key and assert osd_strobe for exactly one cycle; this SHALL NOT touch the FIFO or the modifiers.
REQ-023 key_valid SHALL equal FIFO not-empty; key_data SHALL be the head entry, stable while key_valid=1 and key_ack=0.
REQ-024 key_ack with key_valid=1 SHALL pop one entry; key_ack with key_valid=0 SHALL be ignored.
REQ-025 Push to a full FIFO without a pop SHALL drop the byte and set key_ovf, which then stays set until reset.
REQ-026 Push and pop in the same cycle SHALL both take effect, including when full (no overflow) and when empty with key_valid=0 (push only).
REQ-027 Pointers SHALL be log2(FIFO_DEPTH) bits plus a wrap bit and wrap modulo depth.

Reset
REQ-028 Reset SHALL clear mouse_x, mouse_y, mouse_btn, key_data, key_valid, key_ovf, osd_key, osd_strobe, kbd_reset, the modifier flags and the FIFO pointers.
REQ-029 During reset, lvl_q SHALL load kms_level so that no event fires on the first cycle after reset.
REQ-030 Reset mid-stream SHALL discard FIFO contents; an event in the reset cycle SHALL be lost.

Structure
REQ-031 Package kbd_mouse_pkg SHALL hold the kms_type codes, the modifier keycodes (0x63, 0x66, 0x67) and the release-bit index.
REQ-032 The FIFO SHALL be a sub-module kms_fifo (synchronous, show-ahead, with full/empty flags); the event decode, mouse counters and modifier tracking SHALL live in the top level.

Verification
REQ-033 Toggle kms_level with type 0, data 0x05, then data 0xFA -> mouse_x = 0x05, then 0xFF; mouse_y = 0x00.
REQ-034 Send 9 keycodes 0x10..0x18 with key_ack=0 -> key_valid=1, key_data=0x10, key_ovf=1; acking 8 times yields 0x10..0x17, then key_valid=0.
REQ-035 With the FIFO full, a push and key_ack in the same cycle -> key_ovf stays 0 and the new byte is read last.
REQ-036 Keycodes 0x63, 0x66, 0x67 -> kbd_reset=1 one cycle after the third event; then 0xE6 -> kbd_reset=0.
REQ-037 Type 3, data 0x45 -> osd_key=0x45, osd_strobe high exactly 1 cycle, key_valid stays 0.
REQ-038 Assert reset with 3 entries queued and kms_level=1 -> all outputs 0 and no event on release.
